// File: rtl/node_integrator_multi_pkg.sv
// node_integrator_multi_pkg
//   Constants and helpers shared by the node and transistor models:
//   the default word width, the rail values for a given width, a wide
//   signed clamp and a ceil(log2) helper for sizing accumulators.
package node_integrator_multi_pkg;

  localparam int W_DEF = 16;

  // Upper rail of a signed W-bit voltage word.
  function automatic int rail_hi(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  // Lower rail of a signed W-bit voltage word; also the reset voltage.
  function automatic int rail_lo(input int w);
    return -(2 ** (w - 1));
  endfunction

  // Clamp done at 64 bits so callers can feed any wide intermediate.
  function automatic logic signed [63:0] sclamp(input logic signed [63:0] x,
                                                input logic signed [63:0] lo,
                                                input logic signed [63:0] hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/node_integrator_multi_current_sum_tree.sv
// current_sum_tree
//   Masked, sign-extended sum of N_IN signed channel currents.
//   Purely combinational.
// Ports:
//   i_in   N_IN*W  packed signed currents, channel k at [k*W +: W]
//   i_mask N_IN    1 = channel k included
//   o_sum  SW      signed sum, wide enough that it cannot overflow
module current_sum_tree
  import node_integrator_multi_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int N_IN = 4,
  parameter int SW   = W + clog2(N_IN) + 1
) (
  input  logic [N_IN*W-1:0]   i_in,
  input  logic [N_IN-1:0]     i_mask,
  output logic signed [SW-1:0] o_sum
);

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (i_mask[k]) o_sum = o_sum + SW'($signed(i_in[k*W +: W]));
    end
  end

endmodule

// File: rtl/node_integrator_multi.sv
// node_integrator_multi
//   Clocked node voltage integrator. Each enabled cycle the masked channel
//   currents are summed, scaled by an arithmetic right shift and added to a
//   saturating voltage register. Adds hysteretic logic-level detection and
//   a settle detector so a switch-level netlist can be stepped to quiescence.
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   en           perform one integration step
//   init_valid   load init_v (takes priority over en)
//   init_v       signed load value
//   i_in         packed signed channel currents
//   ch_mask      per-channel include mask
//   v_out        node voltage register
//   logic_out    hysteretic logic level of v_out
//   settled      SETTLE_CYCLES consecutive quiescent steps seen
//   sat          one-cycle pulse: last update was clamped
module node_integrator_multi
  import node_integrator_multi_pkg::*;
#(
  parameter int W             = W_DEF,
  parameter int N_IN          = 4,
  parameter int SHIFT         = 2,
  parameter int VMAX          = rail_hi(W),
  parameter int VMIN          = rail_lo(W),
  parameter int VTH_HI        = 2 ** (W - 3),
  parameter int VTH_LO        = -(2 ** (W - 3)),
  parameter int SETTLE_EPS    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              init_valid,
  input  logic [W-1:0]      init_v,
  input  logic [N_IN*W-1:0] i_in,
  input  logic [N_IN-1:0]   ch_mask,
  output logic [W-1:0]      v_out,
  output logic              logic_out,
  output logic              settled,
  output logic              sat
);

  localparam int SW = W + clog2(N_IN) + 1;
  localparam int CW = clog2(SETTLE_CYCLES + 1);

  localparam logic signed [W-1:0] C_VTH_HI = W'(VTH_HI);
  localparam logic signed [W-1:0] C_VTH_LO = W'(VTH_LO);
  localparam logic [CW-1:0]       C_SC     = CW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]       C_EPS    = SW'(SETTLE_EPS);

  logic signed [W-1:0] r_v;
  logic                r_logic;
  logic                r_settled;
  logic                r_sat;
  logic [CW-1:0]       r_cnt;

  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_delta;
  logic [SW-1:0]        w_delta_abs;
  logic                 w_quiet;
  logic signed [63:0]   w_step;
  logic signed [63:0]   w_init;
  logic signed [63:0]   w_pre;
  logic signed [63:0]   w_clamped;
  logic signed [W-1:0]  w_v_new;
  logic                 w_clip;
  logic                 w_logic_next;
  logic [CW-1:0]        w_cnt_next;

  current_sum_tree #(
    .W    (W),
    .N_IN (N_IN),
    .SW   (SW)
  ) u_sum (
    .i_in   (i_in),
    .i_mask (ch_mask),
    .o_sum  (w_sum)
  );

  assign w_delta = w_sum >>> SHIFT;

  // Magnitude held unsigned so the most negative delta still reads correctly.
  assign w_delta_abs = w_delta[SW-1] ? SW'(-w_delta) : SW'(w_delta);
  assign w_quiet     = (w_delta_abs <= C_EPS);

  assign w_step    = 64'(r_v) + 64'(w_delta);
  assign w_init    = 64'($signed(init_v));
  assign w_pre     = init_valid ? w_init : w_step;
  assign w_clamped = sclamp(w_pre, 64'(VMIN), 64'(VMAX));
  assign w_v_new   = w_clamped[W-1:0];
  assign w_clip    = (w_clamped != w_pre);

  always_comb begin
    w_logic_next = r_logic;
    if (w_v_new >= C_VTH_HI)      w_logic_next = 1'b1;
    else if (w_v_new <= C_VTH_LO) w_logic_next = 1'b0;
  end

  // Counts on the unclamped delta, so a node pinned at a rail stays unsettled.
  always_comb begin
    w_cnt_next = r_cnt;
    if (init_valid || !w_quiet) w_cnt_next = '0;
    else if (r_cnt != C_SC)     w_cnt_next = r_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v       <= W'(VMIN);
      r_logic   <= 1'b0;
      r_settled <= 1'b0;
      r_sat     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sat <= 1'b0;
      if (init_valid || en) begin
        r_v       <= w_v_new;
        r_sat     <= w_clip;
        r_logic   <= w_logic_next;
        r_cnt     <= w_cnt_next;
        r_settled <= (w_cnt_next == C_SC);
      end
    end
  end

  assign v_out     = r_v;
  assign logic_out = r_logic;
  assign settled   = r_settled;
  assign sat       = r_sat;

endmodule

// File: tb/tb_node_integrator_multi.sv
// tb_node_integrator_multi
//   Scoreboard bench: the driver applies one input set per cycle and pushes
//   the expected post-edge outputs from an arithmetic reference model; a
//   monitor pops and compares one entry after every rising edge.
module tb_node_integrator_multi;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          init_valid = 1'b0;
  logic [W-1:0]  init_v = '0;
  logic [N*W-1:0] i_in = '0;
  logic [N-1:0]  ch_mask = '0;
  logic [W-1:0]  v_out;
  logic          logic_out;
  logic          settled;
  logic          sat;

  node_integrator_multi dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .init_valid (init_valid),
    .init_v     (init_v),
    .i_in       (i_in),
    .ch_mask    (ch_mask),
    .v_out      (v_out),
    .logic_out  (logic_out),
    .settled    (settled),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v;
    bit     lg;
    bit     st;
    bit     sa;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference state
  longint m_v   = -32768;
  bit     m_lg  = 0;
  int     m_cnt = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint floor_div4(longint s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  task automatic model_reset();
    m_v = -32768; m_lg = 0; m_cnt = 0;
  endtask

  task automatic step(bit e, bit ini, int iv, int c0, int c1, int c2, int c3,
                      bit [3:0] m);
    int     c[4];
    longint s, d, nv;
    exp_t   x;
    @(negedge clk);
    en = e; init_valid = ini; init_v = 16'(iv); ch_mask = m;
    i_in = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    c = '{c0, c1, c2, c3};
    x.sa = 0;
    if (ini || e) begin
      if (ini) begin
        nv = iv;
        m_cnt = 0;
      end else begin
        s = 0;
        for (int k = 0; k < 4; k++) if (m[k]) s += c[k];
        d = floor_div4(s);
        nv = m_v + d;
        if (d >= -4 && d <= 4) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        else m_cnt = 0;
      end
      if (nv > 32767)  begin nv = 32767;  x.sa = 1; end
      if (nv < -32768) begin nv = -32768; x.sa = 1; end
      m_v = nv;
      if (m_v >= 8192) m_lg = 1;
      else if (m_v <= -8192) m_lg = 0;
    end
    x.v = m_v; x.lg = m_lg; x.st = (m_cnt == 8);
    q.push_back(x);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("v_out", longint'($signed(v_out)), x.v);
        chk("logic_out", longint'(logic_out), longint'(x.lg));
        chk("settled", longint'(settled), longint'(x.st));
        chk("sat", longint'(sat), longint'(x.sa));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int cr[4];
    logic signed [15:0] t;
    reset = 1'b1;
    #12;
    chk("rst_v", longint'($signed(v_out)), -32768);
    reset = 1'b0;

    // 1: reset mid-ramp
    step(0, 1, 5000, 0, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 400, 0, 0, 0, 4'b0001);
    after_edge();
    reset = 1'b1;
    #1;
    chk("rst_mid_v", longint'($signed(v_out)), -32768);
    chk("rst_mid_logic", longint'(logic_out), 0);
    chk("rst_mid_settled", longint'(settled), 0);
    chk("rst_mid_sat", longint'(sat), 0);
    model_reset();
    #1 reset = 1'b0;
    repeat (3) step(0, 0, 0, 123, 0, 0, 0, 4'b1111);

    // 2: basic step, floor rounding, init priority
    step(0, 1, 0, 0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 400, 999, 999, 999, 4'b0001);
    after_edge();
    chk("lit_v100", longint'($signed(v_out)), 100);
    step(1, 0, 0, -1, 0, 0, 0, 4'b0001);
    after_edge();
    chk("lit_floor", longint'($signed(v_out)), 99);
    step(1, 1, 7, 400, 0, 0, 0, 4'b0001);

    // 3: saturation at the top rail
    step(0, 1, 32760, 0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 100, 0, 0, 0, 4'b0001);
    after_edge();
    chk("lit_sat_v", longint'($signed(v_out)), 32767);
    chk("lit_sat", longint'(sat), 1);
    step(1, 0, 0, 100, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 100, 0, 0, 0, 4'b0001);

    // 4: hysteresis
    step(0, 1, 8000, 0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 1000, 0, 0, 0, 4'b0001);
    repeat (2) step(1, 0, 0, -32768, -32768, 0, 0, 4'b0011);
    step(0, 1, 8000, 0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 768, 0, 0, 0, 4'b0001);
    after_edge();
    chk("lit_vth_eq", longint'(logic_out), 1);
    step(0, 1, -8000, 0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, -768, 0, 0, 0, 4'b0001);

    // 5: settle after exactly 8 quiet steps
    step(0, 1, 0, 0, 0, 0, 0, 4'b0011);
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, 0, 8, -4, 0, 0, 4'b0011);
      after_edge();
      chk("lit_settle", longint'(settled), longint'(i >= 8));
    end
    step(1, 0, 0, 100, 0, 0, 0, 4'b0011);
    step(1, 0, 0, 8, -4, 0, 0, 4'b0011);
    step(1, 0, 0, -16, 0, 0, 0, 4'b0001);

    // 6: masking
    step(0, 1, 0, 0, 0, 0, 0, 4'b0001);
    repeat (3) step(1, 0, 0, 40, -30000, 0, 0, 4'b0001);
    step(1, 0, 0, 40, -30000, 0, 0, 4'b0011);

    // random phase
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          t = 16'($urandom);
          cr[k] = int'(t);
        end else begin
          cr[k] = int'($urandom_range(0, 40)) - 20;
        end
      end
      step(bit'($urandom_range(0, 9) < 8), bit'($urandom_range(0, 19) == 0),
           int'($urandom_range(0, 65535)) - 32768,
           cr[0], cr[1], cr[2], cr[3], 4'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
